// File: rtl/disp_pkg.sv
// Shared types and constants for the display page scheduler.
package disp_pkg;

    localparam int PAGE_W = 32;
    localparam logic [PAGE_W-1:0] BLANK_WORD = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_GAP   = 2'd2,
        ST_ALERT = 2'd3
    } disp_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/disp_page_ctrl_rr_next_valid.sv
// Round-robin search for the next valid channel after cur_i, wrapping to 0;
// cur_i itself is checked last so a lone valid channel selects itself.
module rr_next_valid #(
    parameter int CH    = 4,
    parameter int IDX_W = $clog2(CH)
) (
    input  logic [CH-1:0]    valid_i,
    input  logic [IDX_W-1:0] cur_i,
    output logic [IDX_W-1:0] next_o,
    output logic             any_o
);

    logic found;

    always_comb begin
        next_o = cur_i;
        found  = 1'b0;
        for (int k = 1; k <= CH; k++) begin
            int idx;
            idx = (int'(cur_i) + k) % CH;
            if (!found && valid_i[idx]) begin
                next_o = IDX_W'(idx);
                found  = 1'b1;
            end
        end
    end

    assign any_o = |valid_i;

endmodule

// File: rtl/disp_page_ctrl.sv
// Page scheduler sharing the seven-segment display between CH data sources.
// Define DISP_GAP_EN to insert a BLANK_CYC blank gap between rotating pages.
module disp_page_ctrl
    import disp_pkg::*;
#(
    parameter int CH        = 4,
    parameter int DWELL_CYC = 100_000_000,
    parameter int ALERT_CYC = 300_000_000,
    parameter int BLANK_CYC = 10_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CH*PAGE_W-1:0]   ch_data,
    input  logic [CH-1:0]          ch_valid,
    input  logic                   btn_next,
    input  logic                   alert_req,
    input  logic [PAGE_W-1:0]      alert_data,
    output logic                   alert_ack,
    output logic [PAGE_W-1:0]      disp_word,
    output logic                   disp_blank,
    output logic [$clog2(CH)-1:0]  cur_ch
);

    localparam int IDX_W   = $clog2(CH);
    localparam int CNT_MAX = max3(DWELL_CYC, ALERT_CYC, BLANK_CYC);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
    localparam logic [CNT_W-1:0] ALERT_LAST = CNT_W'(ALERT_CYC - 1);
`ifdef DISP_GAP_EN
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
`endif

    disp_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  cur_q, cur_d;
    logic [PAGE_W-1:0] word_q, word_d;
    logic              blank_q, blank_d;
    logic              ack_q, ack_d;

    logic [IDX_W-1:0]  rr_idx, first_idx, resume_ch;
    logic              rr_any, first_any, cur_valid;
    disp_state_e       resume_state;

    rr_next_valid #(.CH(CH), .IDX_W(IDX_W)) u_rr_next (
        .valid_i (ch_valid),
        .cur_i   (cur_q),
        .next_o  (rr_idx),
        .any_o   (rr_any)
    );

    // Starting the search after CH-1 yields the lowest valid index.
    rr_next_valid #(.CH(CH), .IDX_W(IDX_W)) u_rr_first (
        .valid_i (ch_valid),
        .cur_i   (IDX_W'(CH - 1)),
        .next_o  (first_idx),
        .any_o   (first_any)
    );

    assign cur_valid = ch_valid[cur_q];

    always_comb begin
        resume_state = ST_IDLE;
        resume_ch    = cur_q;
        if (cur_valid) begin
            resume_state = ST_SHOW;
        end else if (rr_any) begin
            resume_state = ST_SHOW;
            resume_ch    = rr_idx;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        cur_d   = cur_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (alert_req) begin
                    state_d = ST_ALERT;
                end else if (first_any) begin
                    state_d = ST_SHOW;
                    cur_d   = first_idx;
                end
            end
            ST_SHOW: begin
                if (alert_req) begin
                    state_d = ST_ALERT;
                    cnt_d   = '0;
                end else if (cnt_q == DWELL_LAST || btn_next || !cur_valid) begin
                    cnt_d = '0;
                    if (!rr_any) begin
                        state_d = ST_IDLE;
                    end else begin
                        cur_d = rr_idx;
`ifdef DISP_GAP_EN
                        state_d = ST_GAP;
`else
                        state_d = ST_SHOW;
`endif
                    end
                end
            end
            ST_ALERT: begin
                if (cnt_q == ALERT_LAST) begin
                    cnt_d   = '0;
                    state_d = resume_state;
                    cur_d   = resume_ch;
                end
            end
`ifdef DISP_GAP_EN
            ST_GAP: begin
                if (alert_req) begin
                    state_d = ST_ALERT;
                    cnt_d   = '0;
                end else if (cnt_q == BLANK_LAST) begin
                    cnt_d   = '0;
                    state_d = resume_state;
                    cur_d   = resume_ch;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are derived from the next state so they register with it.
        ack_d   = (state_d == ST_ALERT) && (state_q != ST_ALERT);
        blank_d = !(state_d inside {ST_SHOW, ST_ALERT});
        word_d  = BLANK_WORD;
        if (state_d == ST_SHOW) begin
            word_d = ch_data[int'(cur_d)*PAGE_W +: PAGE_W];
        end else if (state_d == ST_ALERT) begin
            word_d = ack_d ? alert_data : word_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cur_q   <= '0;
            word_q  <= BLANK_WORD;
            blank_q <= 1'b1;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            word_q  <= word_d;
            blank_q <= blank_d;
            ack_q   <= ack_d;
        end
    end

    assign alert_ack  = ack_q;
    assign disp_word  = word_q;
    assign disp_blank = blank_q;
    assign cur_ch     = cur_q;

endmodule

// File: tb/tb_disp_page_ctrl.sv
// Directed bench for disp_page_ctrl with CH=4, DWELL=8, ALERT=5, BLANK=2.
module tb_disp_page_ctrl;

    localparam int CH = 4;
`ifdef DISP_GAP_EN
    localparam int GAP_CYC = 2;
`else
    localparam int GAP_CYC = 0;
`endif

    logic            clk;
    logic            rst;
    logic [CH*32-1:0] ch_data;
    logic [CH-1:0]   ch_valid;
    logic            btn_next;
    logic            alert_req;
    logic [31:0]     alert_data;
    logic            alert_ack;
    logic [31:0]     disp_word;
    logic            disp_blank;
    logic [1:0]      cur_ch;

    logic [31:0]     chw [CH];
    int              n_cmp = 0;
    int              n_mis = 0;

    disp_page_ctrl #(
        .CH        (CH),
        .DWELL_CYC (8),
        .ALERT_CYC (5),
        .BLANK_CYC (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ch_data    (ch_data),
        .ch_valid   (ch_valid),
        .btn_next   (btn_next),
        .alert_req  (alert_req),
        .alert_data (alert_data),
        .alert_ack  (alert_ack),
        .disp_word  (disp_word),
        .disp_blank (disp_blank),
        .cur_ch     (cur_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_data();
        ch_data = {chw[3], chw[2], chw[1], chw[0]};
    endtask

    task automatic check_page(input int c, input int n);
        for (int i = 0; i < n; i++) begin
            chk("page_ch", 32'(cur_ch), 32'(c));
            chk("page_word", disp_word, chw[c]);
            chk("page_blank", 32'(disp_blank), 32'd0);
            chk("page_ack", 32'(alert_ack), 32'd0);
            tick();
        end
    endtask

    task automatic check_gap(input int c, input bit poke);
        for (int i = 0; i < GAP_CYC; i++) begin
            chk("gap_blank", 32'(disp_blank), 32'd1);
            chk("gap_ch", 32'(cur_ch), 32'(c));
            if (poke && i == 0) btn_next = 1'b1;
            tick();
            btn_next = 1'b0;
        end
    endtask

    initial begin
        rst        = 1'b1;
        ch_valid   = '0;
        btn_next   = 1'b0;
        alert_req  = 1'b0;
        alert_data = '0;
        chw[0] = 32'h1111_0000;
        chw[1] = 32'h2222_1111;
        chw[2] = 32'h3333_2222;
        chw[3] = 32'h4444_3333;
        drive_data();
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_word", disp_word, 32'd0);
        chk("rst_blank", 32'(disp_blank), 32'd1);
        chk("rst_cur", 32'(cur_ch), 32'd0);
        chk("rst_ack", 32'(alert_ack), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_blank", 32'(disp_blank), 32'd1);
            chk("idle_word", disp_word, 32'd0);
        end

        // Rotation over 1011 with a live data change on ch0
        ch_valid = 4'b1011;
        tick();
        check_page(0, 3);
        chk("live_old", disp_word, chw[0]);
        chw[0] = 32'h1111_AAAA;
        drive_data();
        tick();
        check_page(0, 4);
        check_gap(1, 1'b0); check_page(1, 8);
        check_gap(3, 1'b0); check_page(3, 8);
        check_gap(0, 1'b0); check_page(0, 8);
        check_gap(1, 1'b0);

        // btn_next at cycle 3 of ch1
        check_page(1, 2);
        chk("btn_pre", 32'(cur_ch), 32'd1);
        btn_next = 1'b1;
        tick();
        btn_next = 1'b0;
        check_gap(3, 1'b0); check_page(3, 8);
        check_gap(0, 1'b0);

        // btn_next coincident with dwell terminal: one advance
        check_page(0, 7);
        chk("term_pre", 32'(cur_ch), 32'd0);
        btn_next = 1'b1;
        tick();
        btn_next = 1'b0;
        check_gap(1, 1'b1); check_page(1, 8);
        check_gap(3, 1'b0); check_page(3, 8);
        check_gap(0, 1'b0);

        // Alert from cycle 4 of ch0
        check_page(0, 3);
        chk("alrt_pre", 32'(cur_ch), 32'd0);
        alert_req  = 1'b1;
        alert_data = 32'hDEAD_BEEF;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("alrt_ack", 32'(alert_ack), (i == 0) ? 32'd1 : 32'd0);
            chk("alrt_word", disp_word, 32'hDEAD_BEEF);
            chk("alrt_blank", 32'(disp_blank), 32'd0);
            chk("alrt_cur", 32'(cur_ch), 32'd0);
            if (i == 0) alert_req = 1'b0;
            btn_next = (i == 1);
            tick();
        end
        btn_next = 1'b0;
        check_page(0, 8);
        check_gap(1, 1'b0);

        // Drop current channel mid-page, then all channels
        check_page(1, 4);
        chk("drop_pre", 32'(cur_ch), 32'd1);
        ch_valid = 4'b1001;
        tick();
        check_gap(3, 1'b0);
        check_page(3, 3);
        ch_valid = 4'b0000;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("idle2_blank", 32'(disp_blank), 32'd1);
            chk("idle2_cur", 32'(cur_ch), 32'd3);
            chk("idle2_word", disp_word, 32'd0);
            tick();
        end

        // Alert from IDLE, reset asserted mid-alert
        alert_req  = 1'b1;
        alert_data = 32'hCAFE_F00D;
        tick();
        chk("ia_ack", 32'(alert_ack), 32'd1);
        chk("ia_word", disp_word, 32'hCAFE_F00D);
        chk("ia_blank", 32'(disp_blank), 32'd0);
        chk("ia_cur", 32'(cur_ch), 32'd3);
        alert_req = 1'b0;
        tick();
        chk("ia2_ack", 32'(alert_ack), 32'd0);
        chk("ia2_word", disp_word, 32'hCAFE_F00D);
        rst = 1'b0;
        tick();
        chk("rst2_word", disp_word, 32'd0);
        chk("rst2_blank", 32'(disp_blank), 32'd1);
        chk("rst2_cur", 32'(cur_ch), 32'd0);
        chk("rst2_ack", 32'(alert_ack), 32'd0);

        // Single valid channel is reselected
        rst      = 1'b1;
        ch_valid = 4'b0100;
        tick();
        check_page(2, 8);
        check_gap(2, 1'b0);
        check_page(2, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/disp_page_ctrl.md
# disp_page_ctrl

Page scheduler that shares the 8-digit seven-segment display between several 32-bit data sources (ALU operands, result, flags, status word). It rotates through the sources with valid content, one page per dwell period, and advances early on a manual "next" pulse. A one-shot alert request pre-empts the rotation for a fixed time. Sits directly upstream of the digit-scan driver and feeds it one 32-bit word plus a blank flag.

## Interface
- CH, 4: number of source channels (2..8)
- DWELL_CYC, 100_000_000: cycles per page in rotation
- ALERT_CYC, 300_000_000: cycles an alert page is held
- BLANK_CYC, 10_000_000: cycles of blank gap between pages (used only with the gap feature)

Ports:
- clk  in  1  system clock; the single clock
- rst  in  1  reset; asynchronous, active-low
- ch_data  in  CH*32  channel c occupies bits [32c+31:32c]
- ch_valid  in  CH  channel c has content to show
- btn_next  in  1  single-cycle pulse, already synchronized and debounced
- alert_req  in  1  level request; held by the requester until acknowledged
- alert_data  in  32  word to show during the alert
- alert_ack  out  1  one-cycle pulse when the alert is accepted
- disp_word  out  32  word to display, registered
- disp_blank  out  1  1 = driver shows all segments off
- cur_ch  out  $clog2(CH)  channel currently shown

## Operation
- States: IDLE, SHOW, GAP, ALERT.
- IDLE: disp_blank=1. When any ch_valid bit is set, go to SHOW on the lowest valid index, with the dwell counter cleared.
- SHOW: disp_blank=0 and disp_word=ch_data[cur_ch]. disp_word tracks live data with one register stage.
- Page advance: triggered by dwell terminal (counter == DWELL_CYC-1), by btn_next, or by the current channel's valid bit dropping.
  - Next channel = first valid index after cur_ch, searched round-robin and wrapping CH-1 to 0.
  - If cur_ch is the only valid channel, it is reselected and the counter restarts.
  - If no channel is valid, go to IDLE.
  - Dwell terminal and btn_next in the same cycle cause a single advance.
- ALERT entry: alert_req=1 in IDLE, SHOW or GAP.
  - Latch alert_data and pulse alert_ack in the cycle the state becomes ALERT.
  - disp_blank=0 and disp_word=latched word for ALERT_CYC cycles.
  - Then return to SHOW on the interrupted cur_ch with the dwell counter cleared. If that channel is now invalid, apply the advance rule; if no channel is valid, go to IDLE.
- During ALERT: alert_req and btn_next are ignored, with no ack; a held request is served after exit.
- cur_ch holds its value through GAP, ALERT and IDLE.
- Reset, whether mid-page or mid-alert: state IDLE, counters 0, no pending ack.

## Timing
- Reset values: disp_word=0, disp_blank=1, cur_ch=0, alert_ack=0.
- All outputs are registered. A state change is visible on the outputs one cycle after the triggering input is sampled.
- A page lasts exactly DWELL_CYC cycles from the first cycle it is displayed.
- alert_ack is high for exactly one cycle, coincident with the first alert word on disp_word.
- The dwell/alert counter is a single shared counter, $clog2(max(DWELL_CYC, ALERT_CYC, BLANK_CYC)) bits wide, cleared on every state entry. It never wraps; terminal compare only.

## Configuration
- DISP_GAP_EN defined:
  - Every SHOW-to-SHOW advance passes through GAP for BLANK_CYC cycles, with disp_blank=1.
  - The next channel is chosen when GAP is entered.
  - btn_next during GAP is ignored.
  - Loss of all valid channels during GAP goes to IDLE at gap end.
- DISP_GAP_EN undefined: GAP is unreachable, advances are immediate, and BLANK_CYC is unused.

## Structure
- Shared package disp_pkg: state enum (IDLE/SHOW/GAP/ALERT), page word width constant 32, blank segment code.
- One sub-module, rr_next_valid: combinational round-robin search of ch_valid starting after cur_ch. Outputs next index and an any-valid flag.

## Test plan
Use CH=4, DWELL_CYC=8, ALERT_CYC=5, BLANK_CYC=2.
- Reset, then ch_valid=4'b0000 for 20 cycles: disp_blank=1 throughout, disp_word=0.
- ch_valid=4'b1011, distinct data per channel: cur_ch sequence 0,1,3,0, each page exactly 8 cycles.
- btn_next at cycle 3 of the page on ch1: ch3 shown from the next cycle. btn_next coincident with dwell terminal gives one advance only.
- alert_req held from cycle 4 of the ch0 page, alert_data=32'hDEAD_BEEF: one-cycle ack, word shown 5 cycles, then ch0 again for a full 8 cycles.
- Drop ch_valid[cur_ch] mid-page: immediate advance. Drop all bits: IDLE with blank. Assert rst mid-alert: reset values next cycle.
- With DISP_GAP_EN: 2 blank cycles between every page and none around the alert; btn_next during the gap has no effect.
